// File: rtl/alu_exec_unit.sv
// EX-stage ALU: resolves ALUOp/Function, executes single-cycle ops and an iterative shift-add MUL.
// Build option: define ALU_SHIFT_EN to enable the SLL/SRL functions (otherwise they decode as ADD).
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Valid,
    input  logic [1:0]        i_ALUOp,
    input  logic [3:0]        i_Function,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    output logic              o_Busy,
    output logic              o_Valid,
    output logic [DATA_W-1:0] o_Result,
    output logic              o_Zero,
    output logic [3:0]        o_ALU_Control
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLT = 4'd4,
        OP_MUL = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    function automatic op_e resolve_op(input logic [1:0] alu_op, input logic [3:0] func);
        op_e op;
        op = OP_ADD;
        case (alu_op)
            2'b01: op = OP_SUB;
            2'b10: op = OP_SLT;
            2'b11: op = OP_ADD;
            default: begin
                case (func)
                    4'b0000: op = OP_ADD;
                    4'b0001: op = OP_SUB;
                    4'b0010: op = OP_AND;
                    4'b0011: op = OP_OR;
                    4'b0100: op = OP_SLT;
                    4'b0101: op = OP_MUL;
`ifdef ALU_SHIFT_EN
                    4'b0110: op = OP_SLL;
                    4'b0111: op = OP_SRL;
`endif
                    default: op = OP_ADD;
                endcase
            end
        endcase
        return op;
    endfunction

    state_e            state, state_next;
    logic [DATA_W-1:0] mcand, mcand_next;
    logic [DATA_W-1:0] mult, mult_next;
    logic [DATA_W-1:0] acc, acc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] result_next;
    logic              zero_next;
    logic              valid_next;
    logic [3:0]        ctrl_next;

    op_e               op;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] acc_step;

    assign op       = resolve_op(i_ALUOp, i_Function);
    assign acc_step = acc + (mult[0] ? mcand : '0);
    assign o_Busy   = (state == S_MUL);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        alu_out = i_A + i_B;
        case (op)
            OP_SUB: alu_out = i_A - i_B;
            OP_AND: alu_out = i_A & i_B;
            OP_OR:  alu_out = i_A | i_B;
            OP_SLT: alu_out = {{(DATA_W-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
`ifdef ALU_SHIFT_EN
            OP_SLL: alu_out = i_A << i_B[CNT_W-1:0];
            OP_SRL: alu_out = i_A >> i_B[CNT_W-1:0];
`endif
            default: alu_out = i_A + i_B;
        endcase
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mult_next   = mult;
        acc_next    = acc;
        cnt_next    = cnt;
        result_next = o_Result;
        zero_next   = o_Zero;
        ctrl_next   = o_ALU_Control;
        valid_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Valid) begin
                    if (op == OP_MUL) begin
                        mcand_next = i_A;
                        mult_next  = i_B;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = S_MUL;
                    end else begin
                        result_next = alu_out;
                        zero_next   = (alu_out == '0);
                        ctrl_next   = op;
                        valid_next  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_next   = acc_step;
                mcand_next = mcand << 1;
                mult_next  = mult >> 1;
                cnt_next   = cnt + CNT_W'(1);
                // The final step's partial sum is the product; publish it directly.
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    cnt_next    = '0;
                    result_next = acc_step;
                    zero_next   = (acc_step == '0);
                    ctrl_next   = OP_MUL;
                    valid_next  = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= S_IDLE;
            mcand         <= '0;
            mult          <= '0;
            acc           <= '0;
            cnt           <= '0;
            o_Valid       <= 1'b0;
            o_Result      <= '0;
            o_Zero        <= 1'b0;
            o_ALU_Control <= '0;
        end else begin
            state         <= state_next;
            mcand         <= mcand_next;
            mult          <= mult_next;
            acc           <= acc_next;
            cnt           <= cnt_next;
            o_Valid       <= valid_next;
            o_Result      <= result_next;
            o_Zero        <= zero_next;
            o_ALU_Control <= ctrl_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (DATA_W=8): directed literal cases plus randomized traffic
// compared every cycle against a behavioural model built on plain integer arithmetic.
module tb_alu_exec_unit;

    localparam int DATA_W = 8;
`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic              i_Clk = 1'b0;
    logic              i_Reset = 1'b1;
    logic              i_Valid = 1'b0;
    logic [1:0]        i_ALUOp = '0;
    logic [3:0]        i_Function = '0;
    logic [DATA_W-1:0] i_A = '0;
    logic [DATA_W-1:0] i_B = '0;
    logic              o_Busy;
    logic              o_Valid;
    logic [DATA_W-1:0] o_Result;
    logic              o_Zero;
    logic [3:0]        o_ALU_Control;

    alu_exec_unit #(.DATA_W(DATA_W)) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Valid(i_Valid),
        .i_ALUOp(i_ALUOp),
        .i_Function(i_Function),
        .i_A(i_A),
        .i_B(i_B),
        .o_Busy(o_Busy),
        .o_Valid(o_Valid),
        .o_Result(o_Result),
        .o_Zero(o_Zero),
        .o_ALU_Control(o_ALU_Control)
    );

    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Operation code implied by ALUOp/Function.
    function automatic int ref_code(input logic [1:0] alu_op, input logic [3:0] func);
        if (alu_op == 2'b01) return 1;
        if (alu_op == 2'b10) return 4;
        if (alu_op == 2'b11) return 0;
        if (func <= 4'd5) return int'(func);
        if (func == 4'd6 || func == 4'd7) return SHIFT_EN ? int'(func) : 0;
        return 0;
    endfunction

    function automatic logic [DATA_W-1:0] ref_value(input int code, input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        longint ia, ib, sa, sb, r;
        ia = longint'(a);
        ib = longint'(b);
        sa = (ia >= 2**(DATA_W-1)) ? ia - 2**DATA_W : ia;
        sb = (ib >= 2**(DATA_W-1)) ? ib - 2**DATA_W : ib;
        case (code)
            0: r = ia + ib;
            1: r = ia - ib;
            2: r = longint'(a & b);
            3: r = longint'(a | b);
            4: r = (sa < sb) ? 1 : 0;
            5: r = ia * ib;
            6: r = ia << (ib % DATA_W);
            7: r = ia >> (ib % DATA_W);
            default: r = 0;
        endcase
        return DATA_W'(r);
    endfunction

    // Behavioural model: a MUL is just a pending product released DATA_W edges after accept.
    bit                model_live = 1'b0;
    int                mul_left = 0;
    logic [DATA_W-1:0] mul_val = '0;
    logic              exp_valid = 1'b0;
    logic [DATA_W-1:0] exp_result = '0;
    logic              exp_zero = 1'b0;
    logic [3:0]        exp_ctrl = '0;

    always @(posedge i_Clk) begin
        model_live <= 1'b1;
        exp_valid  <= 1'b0;
        if (i_Reset) begin
            mul_left   <= 0;
            exp_result <= '0;
            exp_zero   <= 1'b0;
            exp_ctrl   <= '0;
        end else if (mul_left > 1) begin
            mul_left <= mul_left - 1;
        end else if (mul_left == 1) begin
            mul_left   <= 0;
            exp_valid  <= 1'b1;
            exp_result <= mul_val;
            exp_zero   <= (mul_val == '0);
            exp_ctrl   <= 4'd5;
        end else if (i_Valid) begin
            if (ref_code(i_ALUOp, i_Function) == 5) begin
                mul_val  <= ref_value(5, i_A, i_B);
                mul_left <= DATA_W;
            end else begin
                exp_valid  <= 1'b1;
                exp_result <= ref_value(ref_code(i_ALUOp, i_Function), i_A, i_B);
                exp_zero   <= (ref_value(ref_code(i_ALUOp, i_Function), i_A, i_B) == '0);
                exp_ctrl   <= 4'(ref_code(i_ALUOp, i_Function));
            end
        end
    end

    always @(negedge i_Clk) begin
        if (model_live) begin
            check("model_valid", o_Valid, exp_valid);
            check("model_busy", o_Busy, mul_left > 0);
            check("model_result", o_Result, exp_result);
            check("model_zero", o_Zero, exp_zero);
            check("model_ctrl", o_ALU_Control, exp_ctrl);
        end
    end

    // Called just after a negedge; returns at the next negedge with the accept edge's outputs visible.
    task automatic issue(input logic [1:0] alu_op, input logic [3:0] func,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        i_Valid    = 1'b1;
        i_ALUOp    = alu_op;
        i_Function = func;
        i_A        = a;
        i_B        = b;
        @(negedge i_Clk);
        i_Valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;
        int busy_cycles;
        int seen;

        repeat (2) @(negedge i_Clk);
        check("rst_result", o_Result, 0);
        check("rst_zero", o_Zero, 0);
        check("rst_valid", o_Valid, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_ctrl", o_ALU_Control, 0);
        i_Reset = 1'b0;
        @(negedge i_Clk);

        issue(2'b00, 4'b0001, 8'd5, 8'd7);
        check("sub_valid", o_Valid, 1);
        check("sub_result", o_Result, 8'hFE);
        check("sub_zero", o_Zero, 0);
        check("sub_ctrl", o_ALU_Control, 1);
        issue(2'b01, 4'b0000, 8'd3, 8'd3);
        check("beq_result", o_Result, 0);
        check("beq_zero", o_Zero, 1);
        issue(2'b10, 4'b0000, 8'hFF, 8'd1);
        check("slt_neg_lt_pos", o_Result, 1);
        issue(2'b10, 4'b0000, 8'd1, 8'hFF);
        check("slt_pos_lt_neg", o_Result, 0);
        issue(2'b00, 4'b1111, 8'd2, 8'd3);
        check("dflt_result", o_Result, 5);
        check("dflt_ctrl", o_ALU_Control, 0);
        issue(2'b00, 4'b0110, 8'd1, 8'd3);
`ifdef ALU_SHIFT_EN
        check("sll_result", o_Result, 8);
        check("sll_ctrl", o_ALU_Control, 6);
`else
        check("sll_off_result", o_Result, 4);
        check("sll_off_ctrl", o_ALU_Control, 0);
`endif

        // MUL 13*11 with requests poked in while busy.
        issue(2'b00, 4'b0101, 8'd13, 8'd11);
        cycles = 0;
        busy_cycles = 0;
        while (!o_Valid && cycles < 20) begin
            busy_cycles += int'(o_Busy);
            i_Valid = cycles[0];
            i_ALUOp = 2'b11;
            i_A     = 8'd1;
            i_B     = 8'd1;
            @(negedge i_Clk);
            cycles++;
        end
        i_Valid = 1'b0;
        check("mul_latency", cycles, DATA_W);
        check("mul_busy_cycles", busy_cycles, DATA_W);
        check("mul_result", o_Result, 8'h8F);
        check("mul_ctrl", o_ALU_Control, 5);
        @(negedge i_Clk);
        check("mul_no_late_valid", o_Valid, 0);

        // Back-to-back: ADD presented in the MUL's o_Valid cycle.
        issue(2'b00, 4'b0101, 8'd3, 8'd4);
        cycles = 0;
        while (!o_Valid && cycles < 20) begin
            @(negedge i_Clk);
            cycles++;
        end
        check("b2b_mul_latency", cycles, DATA_W);
        check("b2b_mul_result", o_Result, 12);
        issue(2'b11, 4'b0000, 8'd1, 8'd1);
        check("b2b_add_valid", o_Valid, 1);
        check("b2b_add_result", o_Result, 2);

        // Reset three cycles into a MUL aborts it silently.
        issue(2'b00, 4'b0101, 8'd7, 8'd9);
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        check("abort_busy", o_Busy, 0);
        check("abort_valid", o_Valid, 0);
        check("abort_result", o_Result, 0);
        seen = 0;
        repeat (12) begin
            @(negedge i_Clk);
            seen += int'(o_Valid);
        end
        check("abort_no_valid", seen, 0);

        // Randomized traffic with operand corner values and occasional resets.
        for (int n = 0; n < 500; n++) begin
            i_Reset = ($urandom_range(0, 79) == 0);
            i_Valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                i_ALUOp    = 2'b00;
                i_Function = 4'b0101;
            end else begin
                i_ALUOp    = 2'($urandom);
                i_Function = 4'($urandom);
            end
            case ($urandom_range(0, 7))
                0:       i_A = 8'h00;
                1:       i_A = 8'h7F;
                2:       i_A = 8'h80;
                3:       i_A = 8'hFF;
                default: i_A = DATA_W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       i_B = 8'h00;
                1:       i_B = 8'h01;
                2:       i_B = 8'h80;
                3:       i_B = 8'hFF;
                default: i_B = DATA_W'($urandom);
            endcase
            @(negedge i_Clk);
        end
        i_Reset = 1'b0;
        i_Valid = 1'b0;
        repeat (DATA_W + 4) @(negedge i_Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
